// File: rtl/fpir_div_iter_pkg.sv
// rtl/fpir_div_iter_pkg.sv - FPIR field widths, type encodings and divider FSM states
package fpir_div_iter_pkg;

  localparam int BW_FPIR_TYPE   = 3;
  localparam int BW_EXPONENT    = 8;
  localparam int BW_SIGNIFICAND = 24;
  localparam int BW_GUARD       = 3;
  localparam int BW_OVERFLOW    = 1;
  localparam int BW_FPIR_VALUE  = BW_FPIR_TYPE + 1 + BW_EXPONENT + BW_SIGNIFICAND + BW_GUARD + BW_OVERFLOW;

  // One quotient bit per iteration: significand, guard bits and the integer bit.
  localparam int DIV_ITERS = BW_SIGNIFICAND + BW_GUARD + 1;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [BW_FPIR_TYPE-1:0] {
    FPIR_NAN    = 3'd0,
    FPIR_MINF   = 3'd1,
    FPIR_PINF   = 3'd2,
    FPIR_MZERO  = 3'd3,
    FPIR_PZERO  = 3'd4,
    FPIR_NORMAL = 3'd5
  } fpir_type_e;

  typedef struct packed {
    fpir_type_e                typ;
    logic                      sign;
    logic [BW_EXPONENT-1:0]    exp;
    logic [BW_SIGNIFICAND-1:0] sig;
    logic [BW_GUARD-1:0]       guard;
    logic [BW_OVERFLOW-1:0]    ovf;
  } fpir_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic logic is_inf(input fpir_type_e t);
    return (t == FPIR_MINF) || (t == FPIR_PINF);
  endfunction

  function automatic logic is_zero(input fpir_type_e t);
    return (t == FPIR_MZERO) || (t == FPIR_PZERO);
  endfunction

endpackage

// File: rtl/fpir_div_special.sv
// rtl/fpir_div_special.sv - combinational type resolution for FPIR division
module fpir_div_special
  import fpir_div_iter_pkg::*;
(
  input  fpir_type_e type_a,
  input  logic       sign_a,
  input  fpir_type_e type_b,
  input  logic       sign_b,
  output logic       is_special,
  output fpir_type_e result_type,
  output logic       sign,
  output logic       divzero
);

  logic s;

  always_comb begin
    s           = sign_a ^ sign_b;
    is_special  = 1'b1;
    result_type = FPIR_NAN;
    sign        = 1'b0;
    divzero     = 1'b0;
    if (type_a == FPIR_NAN || type_b == FPIR_NAN ||
        (is_inf(type_a) && is_inf(type_b)) || (is_zero(type_a) && is_zero(type_b))) begin
      result_type = FPIR_NAN;
    end else if (is_inf(type_a)) begin
      result_type = s ? FPIR_MINF : FPIR_PINF;
      sign        = s;
    end else if (is_inf(type_b)) begin
      result_type = s ? FPIR_MZERO : FPIR_PZERO;
      sign        = s;
    end else if (is_zero(type_b)) begin
      result_type = s ? FPIR_MINF : FPIR_PINF;
      sign        = s;
      divzero     = 1'b1;
    end else if (is_zero(type_a)) begin
      result_type = s ? FPIR_MZERO : FPIR_PZERO;
      sign        = s;
    end else begin
      is_special  = 1'b0;
      result_type = FPIR_NORMAL;
      sign        = s;
    end
  end

endmodule

// File: rtl/fpir_div_iter.sv
// rtl/fpir_div_iter.sv - iterative restoring FPIR divider, one quotient bit per clock
module fpir_div_iter
  import fpir_div_iter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstp,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BW_FPIR_VALUE-1:0] in_dividend,
  input  logic [BW_FPIR_VALUE-1:0] in_divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BW_FPIR_VALUE-1:0] out_quotient,
  output logic                     out_divzero
);

  localparam int K = DIV_ITERS;
  localparam logic signed [BW_EXPONENT:0] EXP_MAX = (BW_EXPONENT+1)'(2**(BW_EXPONENT-1) - 1);
  localparam logic signed [BW_EXPONENT:0] EXP_MIN = (BW_EXPONENT+1)'(-(2**(BW_EXPONENT-1)));
  localparam logic signed [BW_EXPONENT:0] EXP_ONE = (BW_EXPONENT+1)'(1);

  fpir_t a, b;
  assign a = fpir_t'(in_dividend);
  assign b = fpir_t'(in_divisor);

  logic unused_fields;
  assign unused_fields = ^{a.guard, a.ovf, b.guard, b.ovf};

  logic       sp_is_special, sp_sign, sp_divzero;
  fpir_type_e sp_type;

  fpir_div_special u_special (
    .type_a      (a.typ),
    .sign_a      (a.sign),
    .type_b      (b.typ),
    .sign_b      (b.sign),
    .is_special  (sp_is_special),
    .result_type (sp_type),
    .sign        (sp_sign),
    .divzero     (sp_divzero)
  );

  div_state_e                  state;
  logic [BW_SIGNIFICAND:0]     rem;
  logic [K-1:0]                q;
  logic [CNT_W-1:0]            cnt;
  logic [BW_SIGNIFICAND-1:0]   sig_b;
  logic signed [BW_EXPONENT:0] exp_diff;
  logic                        sign_q;

  // One restoring step; the last step is normalized on the same edge it completes.
  logic                        qbit;
  logic [BW_SIGNIFICAND:0]     rem_sub, rem_nxt;
  logic [K-1:0]                q_nxt;
  logic signed [BW_EXPONENT:0] exp_n;
  logic                        sticky;
  fpir_t                       norm_res, special_res;

  assign qbit    = (rem >= {1'b0, sig_b});
  assign rem_sub = qbit ? (rem - {1'b0, sig_b}) : rem;
  assign rem_nxt = rem_sub << 1;
  assign q_nxt   = {q[K-2:0], qbit};
  assign sticky  = (rem_nxt != '0);

  always_comb begin
    special_res      = '0;
    special_res.typ  = sp_type;
    special_res.sign = sp_sign;

    norm_res      = '0;
    norm_res.sign = sign_q;
    if (q_nxt[K-1]) begin
      exp_n          = exp_diff;
      norm_res.sig   = q_nxt[K-1 -: BW_SIGNIFICAND];
      norm_res.guard = q_nxt[BW_GUARD:1] | {{(BW_GUARD-1){1'b0}}, q_nxt[0] | sticky};
    end else begin
      exp_n          = exp_diff - EXP_ONE;
      norm_res.sig   = q_nxt[K-2 -: BW_SIGNIFICAND];
      norm_res.guard = q_nxt[BW_GUARD-1:0] | {{(BW_GUARD-1){1'b0}}, sticky};
    end
    norm_res.exp = exp_n[BW_EXPONENT-1:0];
    norm_res.typ = FPIR_NORMAL;
    if (exp_n > EXP_MAX) begin
      norm_res      = '0;
      norm_res.typ  = sign_q ? FPIR_MINF : FPIR_PINF;
      norm_res.sign = sign_q;
    end else if (exp_n < EXP_MIN) begin
      norm_res      = '0;
      norm_res.typ  = sign_q ? FPIR_MZERO : FPIR_PZERO;
      norm_res.sign = sign_q;
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_quotient <= '0;
      out_divzero  <= 1'b0;
      rem          <= '0;
      q            <= '0;
      cnt          <= '0;
      sig_b        <= '0;
      exp_diff     <= '0;
      sign_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (sp_is_special) begin
            state        <= S_DONE;
            out_valid    <= 1'b1;
            out_quotient <= special_res;
            out_divzero  <= sp_divzero;
          end else begin
            state    <= S_BUSY;
            rem      <= {1'b0, a.sig};
            q        <= '0;
            cnt      <= '0;
            sig_b    <= b.sig;
            exp_diff <= {a.exp[BW_EXPONENT-1], a.exp} - {b.exp[BW_EXPONENT-1], b.exp};
            sign_q   <= sp_sign;
          end
        end
        S_BUSY: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(K-1)) begin
            state        <= S_DONE;
            out_valid    <= 1'b1;
            out_quotient <= norm_res;
            out_divzero  <= 1'b0;
          end
        end
        S_DONE: if (out_ready) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
